// File: rtl/gf_mul_if.sv
// Request/result bus of the GF(2^8) multiply engine.
// A beat moves on a rising edge where valid & ready are both high; valid must hold its payload until that edge.
interface gf_mul_if #(
  parameter int LANES = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic [7:0]           in_coef;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_coef, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_coef, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gf_mul_engine.sv
// Iterative GF(2^8) multiplier (mod 0x11B): every byte lane times one runtime coefficient, STEPS coef bits per cycle.
// Optional macro GF_MUL_TRIVIAL_BYPASS_EN: coefficients 0x00/0x01 finish after a single cycle for any STEPS.
module gf_mul_engine #(
  parameter int LANES = 16,
  parameter int STEPS = 2
) (
  input  logic       clk,
  input  logic       rst,
  gf_mul_if.slave    bus,
  output logic [1:0] dbg_state
);
  localparam int W    = 8 * LANES;
  localparam int ITER = 8 / STEPS;
  localparam logic [2:0] LAST = 3'(ITER - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, acc_q, acc_d, out_data_q, out_data_d;
  logic [W-1:0]   a_n, acc_n;
  logic [7:0]     b_q, b_d, b_n;
  logic [2:0]     cnt_q, cnt_d;
  logic           in_ready_w, accept;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // STEPS LSB-first shift-and-add steps per cycle; lanes never interact.
  always_comb begin
    a_n   = a_q;
    acc_n = acc_q;
    b_n   = b_q;
    for (int s = 0; s < STEPS; s++) begin
      for (int k = 0; k < LANES; k++) begin
        if (b_n[0]) acc_n[8*k +: 8] = acc_n[8*k +: 8] ^ a_n[8*k +: 8];
        a_n[8*k +: 8] = xtime(a_n[8*k +: 8]);
      end
      b_n = b_n >> 1;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    acc_d      = acc_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    in_ready_w = (state_q == IDLE) | ((state_q == HOLD) & bus.out_ready);
    accept     = bus.in_valid & in_ready_w;

    case (state_q)
      IDLE: ;
      RUN: begin
        a_d   = a_n;
        acc_d = acc_n;
        b_d   = b_n;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST) begin
          state_d    = HOLD;
          out_data_d = acc_n;
          cnt_d      = '0;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = RUN;
      a_d     = bus.in_data;
      b_d     = bus.in_coef;
      acc_d   = '0;
      cnt_d   = '0;
`ifdef GF_MUL_TRIVIAL_BYPASS_EN
      // Only b[0] matters for 0x00/0x01, and the first inner step consumes it.
      if (bus.in_coef[7:1] == 7'd0) cnt_d = LAST;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state_q;
endmodule
